// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU core front end.
//   - PROGRAM_MEM_ADDR_BITS / PROGRAM_MEM_DATA_BITS: default program-memory widths.
//   - core_state_t    : core FSM encoding seen on the fetcher's core_state input.
//   - fetcher_state_t : fetcher FSM encoding driven on fetcher_state.
package gpu_pkg;

  localparam int PROGRAM_MEM_ADDR_BITS = 8;
  localparam int PROGRAM_MEM_DATA_BITS = 16;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_t;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

endpackage

// File: rtl/fetcher_icache_if.sv
// Program-memory read channel between the fetcher and the memory controller.
//   mem_read_valid   : request pending (master -> slave), held until the response.
//   mem_read_address : request address, stable while mem_read_valid is high.
//   mem_read_ready   : response strobe (slave -> master); mem_read_data is valid in that cycle.
//   mem_read_data    : returned instruction.
// Handshake: a request is raised with mem_read_valid and held, address unchanged,
// until the first cycle in which mem_read_ready is high; that cycle completes the
// transfer and the master drops mem_read_valid on the same edge. mem_read_ready
// seen while no request is pending carries no meaning.
interface fetcher_icache_if
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS,
  parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS
);
  logic                 mem_read_valid;
  logic [ADDR_BITS-1:0] mem_read_address;
  logic                 mem_read_ready;
  logic [DATA_BITS-1:0] mem_read_data;

  modport master (
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

  modport slave (
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped, one-instruction-per-line cache storage held in flops.
//   clk, reset       : core clock, asynchronous active-low reset (clears valid bits only).
//   i_lookup_addr    : address looked up combinationally.
//   o_hit, o_data    : lookup result from the registered arrays.
//   i_fill_en/addr/data : synchronous line fill.
//   i_invalidate     : flash-clears every valid bit; beats a same-cycle fill.
module icache_array
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = PROGRAM_MEM_ADDR_BITS,
  parameter int DATA_BITS = PROGRAM_MEM_DATA_BITS,
  parameter int LINES     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] i_lookup_addr,
  output logic                 o_hit,
  output logic [DATA_BITS-1:0] o_data,
  input  logic                 i_fill_en,
  input  logic [ADDR_BITS-1:0] i_fill_addr,
  input  logic [DATA_BITS-1:0] i_fill_data,
  input  logic                 i_invalidate
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     r_valid;
  logic [TAG_BITS-1:0]  r_tag  [LINES];
  logic [DATA_BITS-1:0] r_data [LINES];

  logic [INDEX_BITS-1:0] w_lookup_idx;
  logic [TAG_BITS-1:0]   w_lookup_tag;
  logic [INDEX_BITS-1:0] w_fill_idx;
  logic [TAG_BITS-1:0]   w_fill_tag;

  assign w_lookup_idx = i_lookup_addr[INDEX_BITS-1:0];
  assign w_lookup_tag = i_lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign w_fill_idx   = i_fill_addr[INDEX_BITS-1:0];
  assign w_fill_tag   = i_fill_addr[ADDR_BITS-1:INDEX_BITS];

  assign o_hit  = r_valid[w_lookup_idx] && (r_tag[w_lookup_idx] == w_lookup_tag);
  assign o_data = r_data[w_lookup_idx];

  // Invalidate takes priority: a fill landing on the same edge leaves its line invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (i_invalidate) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data carry no reset; they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= i_fill_data;
    end
  end
endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a small direct-mapped instruction cache.
//   clk, reset    : core clock, asynchronous active-low reset.
//   core_state    : core FSM state; FETCH starts a fetch from IDLE, DECODE releases FETCHED.
//   current_pc    : address to fetch.
//   invalidate    : one-cycle pulse clearing the whole cache.
//   mem (master)  : program-memory read channel, used only on misses.
//   fetcher_state : IDLE / FETCHING / FETCHED (also the FSM debug view).
//   instruction   : fetched instruction, stable while FETCHED and until the next fetch.
//   hit_count, miss_count : saturating event counters.
module fetcher_icache #(
  parameter int PROGRAM_MEM_ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS,
  parameter int PROGRAM_MEM_DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS,
  parameter int CACHE_LINES           = 8,
  parameter int COUNT_BITS            = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  fetcher_icache_if.master                 mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0]            hit_count,
  output logic [COUNT_BITS-1:0]            miss_count
);
  import gpu_pkg::*;

  fetcher_state_t                   r_state;
  logic                             r_mem_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0] r_mem_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0] r_instruction;
  logic [COUNT_BITS-1:0]            r_hit_count;
  logic [COUNT_BITS-1:0]            r_miss_count;

  logic                             w_hit;
  logic [PROGRAM_MEM_DATA_BITS-1:0] w_hit_data;
  logic                             w_fill_en;

  // A response only counts while a request is outstanding.
  assign w_fill_en = (r_state == FETCHER_FETCHING) && mem.mem_read_ready;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_array (
    .clk           (clk),
    .reset         (reset),
    .i_lookup_addr (current_pc),
    .o_hit         (w_hit),
    .o_data        (w_hit_data),
    .i_fill_en     (w_fill_en),
    .i_fill_addr   (r_mem_addr),
    .i_fill_data   (mem.mem_read_data),
    .i_invalidate  (invalidate)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCHER_IDLE;
      r_mem_valid   <= 1'b0;
      r_mem_addr    <= '0;
      r_instruction <= '0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      case (r_state)
        FETCHER_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (w_hit) begin
              r_instruction <= w_hit_data;
              r_state       <= FETCHER_FETCHED;
              if (r_hit_count != {COUNT_BITS{1'b1}}) r_hit_count <= r_hit_count + 1'b1;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_addr  <= current_pc;
              r_state     <= FETCHER_FETCHING;
              if (r_miss_count != {COUNT_BITS{1'b1}}) r_miss_count <= r_miss_count + 1'b1;
            end
          end
        end
        FETCHER_FETCHING: begin
          if (mem.mem_read_ready) begin
            r_mem_valid   <= 1'b0;
            r_instruction <= mem.mem_read_data;
            r_state       <= FETCHER_FETCHED;
          end
        end
        FETCHER_FETCHED: begin
          if (core_state == CORE_DECODE) r_state <= FETCHER_IDLE;
        end
        default: r_state <= FETCHER_IDLE;
      endcase
    end
  end

  assign mem.mem_read_valid   = r_mem_valid;
  assign mem.mem_read_address = r_mem_addr;
  assign fetcher_state        = r_state;
  assign instruction          = r_instruction;
  assign hit_count            = r_hit_count;
  assign miss_count           = r_miss_count;
endmodule

// File: tb/tb_fetcher_icache.sv
// Bench for fetcher_icache: transaction-level cache model (per-line valid/tag/data
// arrays, expected outputs set by the fetch driver), per-cycle compare on the
// falling edge, directed scenarios plus randomized fetch traffic.
module tb_fetcher_icache;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  // Second instance with narrow counters, used for the saturation check.
  logic [2:0]  s_core_state;
  logic [7:0]  s_pc;
  logic        s_invalidate;
  logic [2:0]  s_fetcher_state;
  logic [15:0] s_instruction;
  logic [3:0]  s_hit_count;
  logic [3:0]  s_miss_count;

  fetcher_icache_if mem_if ();
  fetcher_icache_if s_mem_if ();

  fetcher_icache u_dut (
    .clk           (clk),
    .reset         (reset),
    .core_state    (core_state),
    .current_pc    (current_pc),
    .invalidate    (invalidate),
    .mem           (mem_if),
    .fetcher_state (fetcher_state),
    .instruction   (instruction),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  fetcher_icache #(.COUNT_BITS(4)) u_sat (
    .clk           (clk),
    .reset         (reset),
    .core_state    (s_core_state),
    .current_pc    (s_pc),
    .invalidate    (s_invalidate),
    .mem           (s_mem_if),
    .fetcher_state (s_fetcher_state),
    .instruction   (s_instruction),
    .hit_count     (s_hit_count),
    .miss_count    (s_miss_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  int          errors = 0;
  int          checks = 0;
  bit          chk_on = 1'b0;
  bit          m_valid [8];
  logic [4:0]  m_tag   [8];
  logic [15:0] m_data  [8];
  logic [15:0] mem_img [256];
  logic [15:0] exp_q[$];   // instructions the decoder must see, in order

  int          exp_state;
  bit          exp_valid;
  logic [7:0]  exp_addr;
  logic [15:0] exp_instr;
  int          exp_hits;
  int          exp_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("fetcher_state", 32'(fetcher_state), 32'(exp_state));
        chk("mem_read_valid", 32'(mem_if.mem_read_valid), 32'(exp_valid));
        if (exp_valid) chk("mem_read_address", 32'(mem_if.mem_read_address), 32'(exp_addr));
        chk("instruction", 32'(instruction), 32'(exp_instr));
        chk("hit_count", 32'(hit_count), 32'(exp_hits));
        chk("miss_count", 32'(miss_count), 32'(exp_misses));
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [2:0] other_state();
    logic [2:0] pick [6];
    pick[0] = CORE_IDLE;    pick[1] = CORE_REQUEST; pick[2] = CORE_WAIT;
    pick[3] = CORE_EXECUTE; pick[4] = CORE_UPDATE;  pick[5] = CORE_DONE;
    return pick[$urandom_range(0, 5)];
  endfunction

  task automatic do_invalidate();
    invalidate = 1'b1;
    @(posedge clk);
    clear_model();
    @(negedge clk);
    invalidate = 1'b0;
  endtask

  // One full fetch transaction: FETCH, optional memory wait, linger, DECODE.
  // Called and returns at a falling edge.
  task automatic do_fetch(input logic [7:0] pc, input int delay,
                          input bit inv_at_fetch, input bit inv_on_fill);
    int         idx;
    logic [4:0] tg;
    bit         hit;
    logic [15:0] got;
    idx = int'(pc) % 8;
    tg  = 5'(int'(pc) / 8);
    hit = m_valid[idx] && (m_tag[idx] == tg);

    core_state = CORE_FETCH;
    current_pc = pc;
    invalidate = inv_at_fetch;
    @(posedge clk);
    if (hit) begin
      exp_state = 2;
      exp_instr = m_data[idx];
      if (exp_hits < 65535) exp_hits++;
      exp_q.push_back(m_data[idx]);
    end else begin
      exp_state  = 1;
      exp_valid  = 1'b1;
      exp_addr   = pc;
      if (exp_misses < 65535) exp_misses++;
    end
    if (inv_at_fetch) clear_model();
    @(negedge clk);
    invalidate = 1'b0;
    core_state = other_state();
    current_pc = 8'($urandom_range(0, 255));   // fill must use the latched address

    if (!hit) begin
      for (int w = 0; w < delay; w++) begin
        mem_if.mem_read_data = 16'($urandom_range(0, 65535));
        invalidate = ($urandom_range(0, 7) == 0);
        @(posedge clk);
        if (invalidate) clear_model();
        @(negedge clk);
        invalidate = 1'b0;
      end
      mem_if.mem_read_ready = 1'b1;
      mem_if.mem_read_data  = mem_img[pc];
      invalidate = inv_on_fill;
      @(posedge clk);
      exp_state = 2;
      exp_valid = 1'b0;
      exp_instr = mem_img[pc];
      exp_q.push_back(mem_img[pc]);
      m_tag[idx]   = tg;
      m_data[idx]  = mem_img[pc];
      m_valid[idx] = 1'b1;
      if (inv_on_fill) clear_model();
      @(negedge clk);
      mem_if.mem_read_ready = 1'b0;
      invalidate = 1'b0;
    end

    // Linger in FETCHED; stray responses here must be ignored.
    for (int l = 0; l < int'($urandom_range(0, 2)); l++) begin
      core_state = other_state();
      mem_if.mem_read_ready = 1'($urandom_range(0, 1));
      mem_if.mem_read_data  = 16'($urandom_range(0, 65535));
      @(posedge clk);
      @(negedge clk);
    end
    mem_if.mem_read_ready = 1'b0;

    // Decoder latches the instruction during DECODE.
    core_state = CORE_DECODE;
    got = instruction;
    if (exp_q.size() > 0) chk("decoded_instruction", 32'(got), 32'(exp_q.pop_front()));
    else chk("decode_queue_empty", 32'(exp_q.size()), 32'd1);
    @(posedge clk);
    exp_state = 0;
    @(negedge clk);
    core_state = CORE_IDLE;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    core_state = CORE_IDLE;
    current_pc = 8'h00;
    invalidate = 1'b0;
    mem_if.mem_read_ready = 1'b0;
    mem_if.mem_read_data  = 16'h0000;
    s_core_state = CORE_IDLE;
    s_pc = 8'h01;
    s_invalidate = 1'b0;
    s_mem_if.mem_read_ready = 1'b1;
    s_mem_if.mem_read_data  = 16'hA5A5;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom_range(0, 65535));
    mem_img[8'h05] = 16'h3123;
    clear_model();
    exp_state = 0; exp_valid = 1'b0; exp_addr = 8'h00; exp_instr = 16'h0000;
    exp_hits = 0; exp_misses = 0;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Reset values.
    chk("reset_state", 32'(fetcher_state), 32'd0);
    chk("reset_valid", 32'(mem_if.mem_read_valid), 32'd0);
    chk("reset_addr", 32'(mem_if.mem_read_address), 32'd0);
    chk("reset_instr", 32'(instruction), 32'd0);
    chk("reset_counts", {hit_count, miss_count}, 32'd0);

    // Cold miss at 0x05, response after 3 wait cycles.
    do_fetch(8'h05, 3, 1'b0, 1'b0);
    chk("cold_instr", 32'(instruction), 32'h3123);
    chk("cold_miss", 32'(miss_count), 32'd1);

    // Hit at 0x05.
    do_fetch(8'h05, 0, 1'b0, 1'b0);
    chk("hit_instr", 32'(instruction), 32'h3123);
    chk("hit_count1", 32'(hit_count), 32'd1);

    // Conflict eviction: 0x0D shares index 5.
    do_fetch(8'h0D, 1, 1'b0, 1'b0);
    do_fetch(8'h05, 2, 1'b0, 1'b0);
    chk("conflict_miss", 32'(miss_count), 32'd3);
    chk("conflict_instr", 32'(instruction), 32'h3123);

    // Invalidate after fill.
    do_fetch(8'h02, 0, 1'b0, 1'b0);
    do_invalidate();
    do_fetch(8'h02, 0, 1'b0, 1'b0);
    chk("inv_miss", 32'(miss_count), 32'd5);
    // Invalidate coinciding with a fill.
    do_fetch(8'h07, 1, 1'b0, 1'b1);
    chk("inv_fill_instr", 32'(instruction), 32'(mem_img[8'h07]));
    do_fetch(8'h07, 0, 1'b0, 1'b0);
    chk("inv_fill_miss", 32'(miss_count), 32'd7);
    // Invalidate coinciding with a hit lookup: hit still served.
    do_fetch(8'h07, 0, 1'b1, 1'b0);
    chk("inv_hit_count", 32'(hit_count), 32'd2);
    do_fetch(8'h07, 0, 1'b0, 1'b0);
    chk("inv_hit_then_miss", 32'(miss_count), 32'd8);

    // Randomized traffic over three tags per line.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) do_invalidate();
      do_fetch(8'($urandom_range(0, 23)), int'($urandom_range(0, 4)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
    end

    // Reset in the middle of a miss.
    do_invalidate();
    core_state = CORE_FETCH;
    current_pc = 8'h33;
    @(posedge clk);
    exp_state = 1; exp_valid = 1'b1; exp_addr = 8'h33;
    if (exp_misses < 65535) exp_misses++;
    @(negedge clk);
    core_state = CORE_WAIT;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_state = 0; exp_valid = 1'b0; exp_instr = 16'h0000; exp_hits = 0; exp_misses = 0;
    clear_model();
    #1;
    chk("rst_mid_valid", 32'(mem_if.mem_read_valid), 32'd0);
    chk("rst_mid_state", 32'(fetcher_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    core_state = CORE_IDLE;
    mem_if.mem_read_ready = 1'b1;
    mem_if.mem_read_data  = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    mem_if.mem_read_ready = 1'b0;
    chk("late_ready_instr", 32'(instruction), 32'd0);
    chk("late_ready_counts", {hit_count, miss_count}, 32'd0);
    chk("late_ready_state", 32'(fetcher_state), 32'd0);

    // Saturation on the 4-bit-counter instance: one miss, then 20 hits.
    s_core_state = CORE_FETCH;
    @(negedge clk);
    s_core_state = CORE_REQUEST;
    @(negedge clk);
    s_core_state = CORE_DECODE;
    @(negedge clk);
    for (int h = 1; h <= 20; h++) begin
      s_core_state = CORE_FETCH;
      @(negedge clk);
      s_core_state = CORE_DECODE;
      @(negedge clk);
      if (h == 10) chk("sat_hits_10", 32'(s_hit_count), 32'd10);
      if (h == 15) chk("sat_hits_15", 32'(s_hit_count), 32'd15);
    end
    s_core_state = CORE_IDLE;
    chk("sat_hits_final", 32'(s_hit_count), 32'd15);
    chk("sat_miss", 32'(s_miss_count), 32'd1);
    chk("sat_instr", 32'(s_instruction), 32'hA5A5);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
